seg_ctrl_wb: RTL

//  Wishbone slave directly upstream of seven_segment_seconds in the user project.

---
 rtl/seg_ctrl_pkg.sv | 24 ++
 rtl/seg_ctrl_apply.sv | 59 +++++
 rtl/seg_ctrl_wb.sv | 116 +++++++++++
 3 files changed

// File: rtl/seg_ctrl_pkg.sv
// Shared constants and types for the seven-segment Wishbone controller.
// Register offsets, CTRL/STATUS bit positions and the apply FSM states.
package seg_ctrl_pkg;

    localparam logic [3:0] OFF_SHADOW = 4'h0;
    localparam logic [3:0] OFF_CTRL   = 4'h4;
    localparam logic [3:0] OFF_STATUS = 4'h8;
    localparam logic [3:0] OFF_IRQCLR = 4'hC;

    localparam int CTRL_GO     = 0;
    localparam int CTRL_AUTO   = 1;
    localparam int CTRL_IRQ_EN = 2;

    localparam int ST_CNT_LSB = 8;
    localparam int ST_PENDING = 16;

    localparam logic [23:0] CMP_RESET_DEF = 24'h000100;

    typedef enum logic {
        IDLE,
        APPLY
    } apply_state_t;

endpackage

// File: rtl/seg_ctrl_apply.sv
// Apply FSM: loads the shadow value into compare_out and strobes the counter.
// The load uses the next shadow value so bytes written alongside a trigger land.
module seg_ctrl_apply
    import seg_ctrl_pkg::*;
#(
    parameter int               CMP_W     = 24,
    parameter logic [CMP_W-1:0] CMP_RESET = CMP_RESET_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             trigger,
    input  logic [CMP_W-1:0] shadow_d,
    output logic [CMP_W-1:0] compare_out,
    output logic             update_compare,
    output logic [7:0]       count,
    output logic             pending
);

    apply_state_t state, state_nx;
    logic         apply_en;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (trigger) state_nx = APPLY;
            APPLY:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        apply_en = (state == APPLY);
    end

    // A trigger seen while applying folds into the current load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            compare_out    <= CMP_RESET;
            update_compare <= 1'b0;
            count          <= 8'd0;
            pending        <= 1'b0;
        end else begin
            update_compare <= apply_en;
            if (apply_en) begin
                compare_out <= shadow_d;
                count       <= count + 8'd1;
                pending     <= 1'b0;
            end else if (trigger) begin
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_ctrl_wb.sv
// Wishbone slave feeding compare values to seven_segment_seconds.
// Also samples the segment pattern and flags digit changes on irq.
module seg_ctrl_wb
    import seg_ctrl_pkg::*;
#(
    parameter logic [31:0]      BASE_ADDR = 32'h3000_0000,
    parameter int               CMP_W     = 24,
    parameter logic [CMP_W-1:0] CMP_RESET = CMP_RESET_DEF
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_n,
    input  logic             wbs_stb_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [6:0]       led_in,
    output logic             update_compare,
    output logic [CMP_W-1:0] compare_out,
    output logic             irq
);

    logic             in_win, req, wr, rd;
    logic [3:0]       off;
    logic             wr_shadow, wr_ctrl, wr_irqclr;
    logic             go, trigger, irq_set;
    logic             auto_q, irq_en;
    logic [CMP_W-1:0] shadow, shadow_d;
    logic [31:0]      mask, merged, rdata;
    logic [6:0]       led_q, led_q_d;
    logic [7:0]       count;
    logic             pending;
    logic             unused_ok;

    assign off    = wbs_adr_i[3:0];
    assign in_win = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign req    = wbs_stb_i & wbs_cyc_i & in_win & ~wbs_ack_o;
    assign wr     = req & wbs_we_i;
    assign rd     = req & ~wbs_we_i;

    assign wr_shadow = wr && (off == OFF_SHADOW);
    assign wr_ctrl   = wr && (off == OFF_CTRL) && wbs_sel_i[0];
    assign wr_irqclr = wr && (off == OFF_IRQCLR);

    assign go      = wr_ctrl & wbs_dat_i[CTRL_GO];
    assign trigger = go | (wr_shadow & auto_q);
    assign irq_set = irq_en & (led_q != led_q_d);

    assign mask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                   {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign merged = ({{(32-CMP_W){1'b0}}, shadow} & ~mask)
                  | (wbs_dat_i & mask);
    assign shadow_d  = wr_shadow ? merged[CMP_W-1:0] : shadow;
    assign unused_ok = ^merged[31:CMP_W];

    always_comb begin
        rdata = '0;
        unique case (1'b1)
            (off == OFF_SHADOW): rdata[CMP_W-1:0] = shadow;
            (off == OFF_CTRL): begin
                rdata[CTRL_AUTO]   = auto_q;
                rdata[CTRL_IRQ_EN] = irq_en;
            end
            (off == OFF_STATUS): begin
                rdata[6:0]               = led_q;
                rdata[ST_CNT_LSB +: 8]   = count;
                rdata[ST_PENDING]        = pending;
            end
            default: rdata = '0;
        endcase
    end

    // A digit change in the same cycle as IRQCLR keeps irq set.
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            shadow    <= CMP_RESET;
            auto_q    <= 1'b0;
            irq_en    <= 1'b0;
            led_q     <= '0;
            led_q_d   <= '0;
            irq       <= 1'b0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= rd ? rdata : '0;
            shadow    <= shadow_d;
            if (wr_ctrl) begin
                auto_q <= wbs_dat_i[CTRL_AUTO];
                irq_en <= wbs_dat_i[CTRL_IRQ_EN];
            end
            led_q   <= led_in;
            led_q_d <= led_q;
            if (irq_set)        irq <= 1'b1;
            else if (wr_irqclr) irq <= 1'b0;
        end
    end

    seg_ctrl_apply #(
        .CMP_W     (CMP_W),
        .CMP_RESET (CMP_RESET)
    ) u_apply (
        .clk            (wb_clk_i),
        .rst_n          (wb_rst_n),
        .trigger        (trigger),
        .shadow_d       (shadow_d),
        .compare_out    (compare_out),
        .update_compare (update_compare),
        .count          (count),
        .pending        (pending)
    );

endmodule
